// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_CORR = 4'd6;
   localparam logic [3:0] BCD_MAX  = 4'd9;

   // True when a 4-bit digit lies outside the decimal range.
   function automatic logic digit_invalid(input logic [3:0] dig);
      return (dig > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit cell: binary add, decimal-correction flag, +6 fix-up.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a_d,
   input  logic [3:0] b_d,
   input  logic       c_in,
   output logic [3:0] d,
   output logic       c_out
);

   logic [4:0] s;
   logic       f;

   // Binary digit sum, correction flag and corrected digit.
   always_comb begin
      s     = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
      f     = s[4] | (s[3] & (s[2] | s[1]));
      d     = f ? (s[3:0] + BCD_CORR) : s[3:0];
      c_out = f;
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one shared digit cell driven by a
// small IDLE/RUN/DONE controller, one digit per clock.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int W  = 4 * DIGITS;
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  work_q, work_d;
   logic          err_lat_q, err_lat_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          err_q, err_d;

   logic [3:0]    cell_a, cell_b, cell_d;
   logic          cell_c;
   logic          in_bad;

   bcd_digit_add u_digit (
      .a_d   (cell_a),
      .b_d   (cell_b),
      .c_in  (carry_q),
      .d     (cell_d),
      .c_out (cell_c)
   );

   // Select the operand digits addressed by idx and flag invalid input digits.
   always_comb begin
      cell_a = '0;
      cell_b = '0;
      in_bad = 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cell_a = a_q[4*k +: 4];
            cell_b = b_q[4*k +: 4];
         end
         in_bad = in_bad | digit_invalid(a[4*k +: 4]) | digit_invalid(b[4*k +: 4]);
      end
   end

   // Controller next state and datapath register updates.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      carry_d   = carry_q;
      work_d    = work_q;
      err_lat_d = err_lat_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      err_d     = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               a_d       = a;
               b_d       = b;
               carry_d   = cin;
               work_d    = '0;
               idx_d     = '0;
               err_lat_d = in_bad;
            end
         end
         RUN: begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
               if (idx_q == IW'(k)) begin
                  work_d[4*k +: 4] = cell_d;
               end
            end
            carry_d = cell_c;
            idx_d   = idx_q + 1'b1;
            // The final digit is folded straight into the output registers
            // so the result is visible on the same edge that enters DONE.
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
               idx_d   = '0;
               sum_d   = work_d;
               cout_d  = cell_c;
               err_d   = err_lat_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         work_q    <= '0;
         err_lat_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         carry_q   <= carry_d;
         work_q    <= work_d;
         err_lat_q <= err_lat_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         err_q     <= err_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder with a result scoreboard.
module tb_bcd_serial_adder;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         e;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, err;
   logic [W-1:0] sum;

   res_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Decimal reference: a digit total above nine wraps by +6 and carries.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
      res_t r;
      int   c;
      int   t;
      logic [3:0] da, db;
      r = '0;
      c = int'(mc);
      for (int k = 0; k < DIGITS; k++) begin
         da = ma[4*k +: 4];
         db = mb[4*k +: 4];
         if (da > 4'd9 || db > 4'd9) r.e = 1'b1;
         t = int'(da) + int'(db) + c;
         if (t > 9) begin
            r.s[4*k +: 4] = 4'((t + 6) % 16);
            c = 1;
         end else begin
            r.s[4*k +: 4] = 4'(t);
            c = 0;
         end
      end
      r.c = (c != 0);
      return r;
   endfunction

   // One operation: drive, wait for done within a bound, check timing and result.
   // cyc counts the start cycle as 1, so done appears at cyc == DIGITS+1.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input bit poke);
      int   cyc;
      int   bcnt;
      bit   seen;
      res_t exp;
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
      sb.push_back(model(ta, tb, tc));
      @(posedge clk); #1;
      start = 1'b0;
      cyc  = 1;
      bcnt = busy ? 1 : 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         if (poke && cyc == 2) begin
            start = 1'b1; a = 16'h5555; b = 16'h4444; cin = 1'b1;
         end
         if (poke && cyc == 4) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
         if (busy) bcnt++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(cyc), 32'(DIGITS + 1));
      chk("busy_cycles", 32'(bcnt), 32'(DIGITS));
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         chk("sum", 32'(sum), 32'(exp.s));
         chk("cout", 32'(cout), 32'(exp.c));
         chk("err", 32'(err), 32'(exp.e));
      end else begin
         chk("sb_empty", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           dcnt;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;

      run_op(16'h0999, 16'h0001, 1'b0, 1'b0);
      run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
      run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
      run_op(16'h0008, 16'h0008, 1'b0, 1'b0);
      run_op(16'h000A, 16'h0000, 1'b0, 1'b0);
      run_op(16'h0123, 16'h0456, 1'b0, 1'b0);
      run_op(16'h2718, 16'h3141, 1'b0, 1'b1);
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < DIGITS; k++) begin
            ra[4*k +: 4] = 4'($urandom_range(9, 0));
            rb[4*k +: 4] = 4'($urandom_range(9, 0));
         end
         run_op(ra, rb, 1'($urandom_range(1, 0)), 1'b0);
      end
      run_op(16'h9999, 16'h9999, 1'b1, 1'b0);

      // Abort an operation on its second RUN cycle; outputs were non-zero.
      @(negedge clk);
      a = 16'h0777; b = 16'h0222; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      dcnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      chk("abort_no_done", 32'(dcnt), 32'd0);
      run_op(16'h4567, 16'h5432, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
